// File: rtl/led_pkg.sv
// Shared definitions for the LED pad-bank controller: register map,
// controller states and register reset values.
package led_pkg;

   localparam logic [1:0] LED_ADDR_LED   = 2'd0;
   localparam logic [1:0] LED_ADDR_DUTY  = 2'd1;
   localparam logic [1:0] LED_ADDR_BMASK = 2'd2;
   localparam logic [1:0] LED_ADDR_BDIV  = 2'd3;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SLEEP = 2'd2,
      WAKE  = 2'd3
   } led_state_t;

   localparam logic [7:0] LED_RST_LED   = 8'h00;
   localparam logic [7:0] LED_RST_DUTY  = 8'hFF;
   localparam logic [7:0] LED_RST_BMASK = 8'h00;
   localparam logic [7:0] LED_RST_BDIV  = 8'h00;

endpackage

// File: rtl/led_blink_timer.sv
// Blink timebase: a free-running prescaler produces a tick on every wrap,
// and the tick counter flips the blink phase every (bdiv+1) ticks.
module led_blink_timer
   import led_pkg::*;
#(
   parameter int TICK_W = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bdiv,
   output logic       phase
);

   localparam logic [TICK_W-1:0] PRE_ONE = TICK_W'(1);
   localparam logic [TICK_W-1:0] PRE_MAX = {TICK_W{1'b1}};

   logic [TICK_W-1:0] prescale;
   logic [7:0]        tick_cnt;
   logic              tick;

   // The tick is the edge on which the prescaler wraps back to zero.
   assign tick = (prescale == PRE_MAX);

   // Prescaler and tick counter; a bdiv below the counter simply lets it wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescale <= '0;
         tick_cnt <= 8'd0;
         phase    <= 1'b0;
      end else begin
         prescale <= prescale + PRE_ONE;
         if (tick) begin
            if (tick_cnt == bdiv) begin
               tick_cnt <= 8'd0;
               phase    <= ~phase;
            end else begin
               tick_cnt <= tick_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED pad-bank controller: register file, PWM dimming, blink masking and
// the WFI sequencer that drains the pads before gating their output-enable.
module led_pwm_ctrl
   import led_pkg::*;
#(
   parameter int TICK_W = 16,
   parameter int SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   input  logic       wfi_req,
   output logic       wfi_ack,
   output logic [7:0] led_bus,
   output logic       led_gate
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

   logic [7:0] led_reg;
   logic [7:0] duty_reg;
   logic [7:0] bmask_reg;
   logic [7:0] bdiv_reg;
   logic [7:0] pcnt;
   logic       pwm_on;
   logic       phase;
   led_state_t state;
   logic [7:0] settle_cnt;

   led_blink_timer #(
      .TICK_W (TICK_W)
   ) u_blink (
      .clk   (clk),
      .rst_n (rst_n),
      .bdiv  (bdiv_reg),
      .phase (phase)
   );

   // Register file; a read in the same cycle as a write returns the old value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_reg   <= LED_RST_LED;
         duty_reg  <= LED_RST_DUTY;
         bmask_reg <= LED_RST_BMASK;
         bdiv_reg  <= LED_RST_BDIV;
         rdata     <= 8'h00;
      end else begin
         if (rd_en) begin
            case (addr)
               LED_ADDR_LED:   rdata <= led_reg;
               LED_ADDR_DUTY:  rdata <= duty_reg;
               LED_ADDR_BMASK: rdata <= bmask_reg;
               LED_ADDR_BDIV:  rdata <= bdiv_reg;
            endcase
         end
         if (wr_en) begin
            case (addr)
               LED_ADDR_LED:   led_reg   <= wdata;
               LED_ADDR_DUTY:  duty_reg  <= wdata;
               LED_ADDR_BMASK: bmask_reg <= wdata;
               LED_ADDR_BDIV:  bdiv_reg  <= wdata;
            endcase
         end
      end
   end

   // Free-running PWM counter, kept running through every controller state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt <= 8'd0;
      end else begin
         pcnt <= pcnt + 8'd1;
      end
   end

   assign pwm_on = (pcnt < duty_reg);

   // WFI sequencer; gate and ack trail the state by one edge so the pads sit
   // low for SETTLE cycles before gating and stay ungated SETTLE cycles after.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         settle_cnt <= 8'd0;
         led_gate   <= 1'b0;
         wfi_ack    <= 1'b0;
      end else begin
         led_gate <= (state == SLEEP);
         wfi_ack  <= (state == SLEEP) || (state == WAKE);
         case (state)
            RUN: begin
               if (wfi_req && !wfi_ack) begin
                  state      <= DRAIN;
                  settle_cnt <= 8'd0;
               end
            end
            DRAIN: begin
               if (!wfi_req) begin
                  state <= RUN;
               end else if (settle_cnt == SETTLE_LAST) begin
                  state <= SLEEP;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
            SLEEP: begin
               if (!wfi_req) begin
                  state      <= WAKE;
                  settle_cnt <= 8'd0;
               end
            end
            WAKE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= RUN;
               end else begin
                  settle_cnt <= settle_cnt + 8'd1;
               end
            end
         endcase
      end
   end

   // Pad data: pattern only in RUN once the ack has dropped, otherwise low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_bus <= 8'h00;
      end else if ((state == RUN) && !wfi_ack) begin
         led_bus <= led_reg & {8{pwm_on}} & ~(bmask_reg & {8{phase}});
      end else begin
         led_bus <= 8'h00;
      end
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl with a fast blink timebase.
module tb_led_pwm_ctrl;

   localparam int TICK_W = 4;
   localparam int SETTLE = 4;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic       rd_en;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       wfi_req;
   logic       wfi_ack;
   logic [7:0] led_bus;
   logic       led_gate;

   int errors = 0;
   int checks = 0;

   // Reference model state: register contents, edges since reset, blink state.
   logic [7:0] m_reg [4];
   int         m_t;
   int         m_bcnt;
   logic       m_phase;
   logic [7:0] m_pattern;
   logic [7:0] m_rdata;

   led_pwm_ctrl #(
      .TICK_W (TICK_W),
      .SETTLE (SETTLE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .wfi_req  (wfi_req),
      .wfi_ack  (wfi_ack),
      .led_bus  (led_bus),
      .led_gate (led_gate)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: PWM position is the edge count mod 256, a blink tick
   // arrives every 2^TICK_W edges, and the RUN pattern follows the formula.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_reg[0]  = 8'h00;
         m_reg[1]  = 8'hFF;
         m_reg[2]  = 8'h00;
         m_reg[3]  = 8'h00;
         m_t       = 0;
         m_bcnt    = 0;
         m_phase   = 1'b0;
         m_pattern = 8'h00;
         m_rdata   = 8'h00;
      end else begin
         m_pattern = ((m_t % 256) < int'(m_reg[1])) ? m_reg[0] : 8'h00;
         if (m_phase) m_pattern = m_pattern & ~m_reg[2];
         if (rd_en) m_rdata = m_reg[addr];
         if (((m_t + 1) % (1 << TICK_W)) == 0) begin
            if (m_bcnt == int'(m_reg[3])) begin
               m_bcnt  = 0;
               m_phase = !m_phase;
            end else begin
               m_bcnt = (m_bcnt + 1) % 256;
            end
         end
         if (wr_en) m_reg[addr] = wdata;
         m_t = m_t + 1;
      end
   end

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      rd_en = 1'b1;
      addr  = a;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] exp_vals [4];
      exp_vals[0] = 8'h00;
      exp_vals[1] = 8'hFF;
      exp_vals[2] = 8'h00;
      exp_vals[3] = 8'h00;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (led_bus !== 8'h00 || led_gate !== 1'b0 || wfi_ack !== 1'b0 || rdata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_outputs: bus=%h gate=%b ack=%b rdata=%h expected 00/0/0/00",
                  led_bus, led_gate, wfi_ack, rdata);
      end
      rst_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         checks++;
         if (rdata !== exp_vals[a]) begin
            errors++;
            $display("[TB] FAIL reset_read[%0d]: got %h expected %h", a, rdata, exp_vals[a]);
         end
      end
   endtask

   task automatic test_regs();
      logic [7:0] v;
      logic [7:0] v2;
      for (int a = 0; a < 4; a++) begin
         v = 8'($urandom);
         wr(2'(a), v);
         rd(2'(a));
         checks++;
         if (rdata !== v) begin
            errors++;
            $display("[TB] FAIL reg_readback[%0d]: got %h expected %h", a, rdata, v);
         end
      end
      v  = 8'($urandom);
      v2 = ~v;
      wr(2'(0), v);
      rd_en = 1'b1;
      wr_en = 1'b1;
      addr  = 2'd0;
      wdata = v2;
      @(negedge clk);
      rd_en = 1'b0;
      wr_en = 1'b0;
      checks++;
      if (rdata !== v) begin
         errors++;
         $display("[TB] FAIL read_during_write: got %h expected old %h", rdata, v);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (rdata !== v) begin
         errors++;
         $display("[TB] FAIL rdata_hold: got %h expected %h", rdata, v);
      end
      rd(2'(0));
      checks++;
      if (rdata !== v2) begin
         errors++;
         $display("[TB] FAIL write_after_rw: got %h expected %h", rdata, v2);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         wr_en = ($urandom_range(0, 3) == 0);
         rd_en = ($urandom_range(0, 1) == 0);
         addr  = 2'($urandom);
         wdata = 8'($urandom);
         @(negedge clk);
         checks++;
         if (led_bus !== m_pattern) begin
            errors++;
            $display("[TB] FAIL random_led_bus: cycle %0d got %h expected %h", c, led_bus, m_pattern);
         end
         checks++;
         if (rdata !== m_rdata) begin
            errors++;
            $display("[TB] FAIL random_rdata: cycle %0d got %h expected %h", c, rdata, m_rdata);
         end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_pwm();
      int on_cnt;
      int off_cnt;
      wr(2'(2), 8'h00);
      wr(2'(0), 8'hA5);
      wr(2'(1), 8'h80);
      @(negedge clk);
      on_cnt  = 0;
      off_cnt = 0;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         if (led_bus === 8'hA5) on_cnt++;
         if (led_bus === 8'h00) off_cnt++;
         checks++;
         if (led_bus !== m_pattern) begin
            errors++;
            $display("[TB] FAIL pwm_half_bus: cycle %0d got %h expected %h", c, led_bus, m_pattern);
         end
      end
      checks++;
      if (on_cnt != 128 || off_cnt != 128) begin
         errors++;
         $display("[TB] FAIL pwm_half_count: on=%0d off=%0d expected 128/128", on_cnt, off_cnt);
      end
      wr(2'(1), 8'h00);
      @(negedge clk);
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         checks++;
         if (led_bus !== 8'h00) begin
            errors++;
            $display("[TB] FAIL pwm_zero_duty: cycle %0d got %h expected 00", c, led_bus);
         end
      end
   endtask

   task automatic test_blink();
      logic [7:0] last_nz;
      int         last_toggle;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wr(2'(0), 8'hFF);
      wr(2'(2), 8'h0F);
      wr(2'(3), 8'h01);
      last_nz     = 8'h00;
      last_toggle = -1;
      for (int c = 0; c < 220; c++) begin
         @(negedge clk);
         checks++;
         if (led_bus !== m_pattern) begin
            errors++;
            $display("[TB] FAIL blink_bus: cycle %0d got %h expected %h", c, led_bus, m_pattern);
         end
         checks++;
         if (led_bus !== 8'hFF && led_bus !== 8'hF0 && led_bus !== 8'h00) begin
            errors++;
            $display("[TB] FAIL blink_high_nibble: cycle %0d got %h expected FF/F0/00", c, led_bus);
         end
         if (led_bus !== 8'h00) begin
            if (last_nz !== 8'h00 && led_bus !== last_nz) begin
               if (last_toggle >= 0) begin
                  checks++;
                  if (c - last_toggle != 32) begin
                     errors++;
                     $display("[TB] FAIL blink_period: got %0d cycles expected 32", c - last_toggle);
                  end
               end
               last_toggle = c;
            end
            last_nz = led_bus;
         end
      end
   endtask

   task automatic test_wfi();
      wr(2'(2), 8'h00);
      wr(2'(1), 8'hFF);
      wr(2'(0), 8'h5A);
      @(negedge clk);
      wfi_req = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         checks++;
         if (led_gate !== (j >= 5) || wfi_ack !== (j >= 5)) begin
            errors++;
            $display("[TB] FAIL wfi_entry_handshake: k+%0d gate=%b ack=%b expected %b/%b",
                     j, led_gate, wfi_ack, j >= 5, j >= 5);
         end
         checks++;
         if (led_bus !== ((j == 0) ? m_pattern : 8'h00)) begin
            errors++;
            $display("[TB] FAIL wfi_entry_bus: k+%0d got %h expected %h",
                     j, led_bus, (j == 0) ? m_pattern : 8'h00);
         end
      end
      wfi_req = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         checks++;
         if (led_gate !== (j < 1) || wfi_ack !== (j < 5)) begin
            errors++;
            $display("[TB] FAIL wfi_exit_handshake: m+%0d gate=%b ack=%b expected %b/%b",
                     j, led_gate, wfi_ack, j < 1, j < 5);
         end
         checks++;
         if (led_bus !== ((j >= 6) ? m_pattern : 8'h00)) begin
            errors++;
            $display("[TB] FAIL wfi_exit_bus: m+%0d got %h expected %h",
                     j, led_bus, (j >= 6) ? m_pattern : 8'h00);
         end
      end
   endtask

   task automatic test_abort();
      @(negedge clk);
      for (int j = 0; j < 8; j++) begin
         wfi_req = (j < 2);
         @(negedge clk);
         checks++;
         if (led_gate !== 1'b0 || wfi_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_handshake: k+%0d gate=%b ack=%b expected 0/0", j, led_gate, wfi_ack);
         end
         checks++;
         if (led_bus !== ((j == 1 || j == 2) ? 8'h00 : m_pattern)) begin
            errors++;
            $display("[TB] FAIL abort_bus: k+%0d got %h expected %h",
                     j, led_bus, (j == 1 || j == 2) ? 8'h00 : m_pattern);
         end
      end
      wfi_req = 1'b0;
   endtask

   task automatic test_sleep_write();
      wfi_req = 1'b1;
      repeat (6) @(negedge clk);
      wr(2'(0), 8'h3C);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++;
         if (led_gate !== 1'b1 || led_bus !== 8'h00) begin
            errors++;
            $display("[TB] FAIL sleep_write_gated: gate=%b bus=%h expected 1/00", led_gate, led_bus);
         end
      end
      wfi_req = 1'b0;
      repeat (6) @(negedge clk);
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         checks++;
         if (led_bus !== m_pattern || (led_bus !== 8'h3C && led_bus !== 8'h00)) begin
            errors++;
            $display("[TB] FAIL sleep_write_resume: got %h expected %h", led_bus, m_pattern);
         end
      end
   endtask

   task automatic test_reset_mid();
      wfi_req = 1'b1;
      repeat (7) @(negedge clk);
      rst_n   = 1'b0;
      wfi_req = 1'b0;
      @(negedge clk);
      checks++;
      if (led_gate !== 1'b0 || wfi_ack !== 1'b0 || led_bus !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_mid_sequence: gate=%b ack=%b bus=%h expected 0/0/00",
                  led_gate, wfi_ack, led_bus);
      end
      rst_n = 1'b1;
      rd(2'(0));
      checks++;
      if (rdata !== 8'h00 || led_gate !== 1'b0 || wfi_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_after: rdata=%h gate=%b ack=%b expected 00/0/0",
                  rdata, led_gate, wfi_ack);
      end
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      addr    = 2'd0;
      wdata   = 8'h00;
      wfi_req = 1'b0;
      @(negedge clk);
      test_reset();
      test_regs();
      test_random();
      test_pwm();
      test_blink();
      test_wfi();
      test_abort();
      test_sleep_write();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
